// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction-fetch stage feeding IF/ID.
// Variable-latency imem req/ack, 1-entry skid, redirect drop, timeout.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] Addr,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_SKID,
    S_DROP
  } state_t;

  localparam logic [15:0] LP_TO = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic [31:0] r_drop_addr;
  logic [31:0] r_sk_instr;
  logic [31:0] r_sk_addr;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_req;
  logic        w_ack;
  logic        w_take;
  logic        w_skid;
  logic        w_sk_ld;
  logic        w_drop_ld;
  logic [31:0] w_pc4;
  logic [31:0] w_tgt;

  // Handshake qualifiers; r_run keeps the request low until after reset.
  always_comb begin
    w_req  = r_run && (r_state != S_SKID);
    w_ack  = w_req && imem_ack;
    w_pc4  = r_pc + 32'd4;
    w_tgt  = redirect_addr & ~32'd3;
    w_take = (r_state == S_FETCH) && w_ack
          && !redirect_valid;
    w_skid = (r_state == S_SKID) && !redirect_valid;
  end

  // Next-state, next-pc and skid/drop load decisions.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_sk_ld    = 1'b0;
    w_drop_ld  = 1'b0;
    if (redirect_valid) begin
      w_pc_nx = w_tgt;
      if (w_req && !imem_ack) begin
        w_state_nx = S_DROP;
        w_drop_ld  = (r_state == S_FETCH);
      end else begin
        w_state_nx = S_FETCH;
      end
    end else begin
      unique case (1'b1)
        (r_state == S_FETCH): begin
          if (w_ack) begin
            w_pc_nx = w_pc4;
            if (hold) begin
              w_state_nx = S_SKID;
              w_sk_ld    = 1'b1;
            end
          end
        end
        (r_state == S_SKID): begin
          if (!hold) w_state_nx = S_FETCH;
        end
        (r_state == S_DROP): begin
          if (w_ack) w_state_nx = S_FETCH;
        end
        default: w_state_nx = S_FETCH;
      endcase
    end
  end

  // State, pc, run flag and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_drop_addr <= 32'd0;
      r_sk_instr  <= 32'd0;
      r_sk_addr   <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= 1'b1;
      r_pc    <= w_pc_nx;
      if (w_drop_ld) r_drop_addr <= r_pc;
      if (w_sk_ld) begin
        r_sk_instr <= imem_rdata;
        r_sk_addr  <= w_pc4;
      end else if (redirect_valid
                || (r_state == S_SKID && !hold)) begin
        r_sk_instr <= 32'd0;
        r_sk_addr  <= 32'd0;
      end
    end
  end

  // Wait counter for unanswered requests and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
      r_err <= 1'b0;
    end else if (w_ack) begin
      r_cnt <= 16'd0;
    end else if (w_req && r_cnt != LP_TO) begin
      r_cnt <= r_cnt + 16'd1;
      if (r_cnt + 16'd1 == LP_TO) r_err <= 1'b1;
    end
  end

  // Outputs toward imem and IF/ID; bubbles are all-zero.
  always_comb begin
    imem_req  = w_req;
    imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    Instr     = 32'd0;
    Addr      = 32'd0;
    if (w_take) begin
      Instr = imem_rdata;
      Addr  = w_pc4;
    end else if (w_skid) begin
      Instr = r_sk_instr;
      Addr  = r_sk_addr;
    end
    if_id_hold  = r_run && hold && !redirect_valid;
    if_id_flush = !r_run || redirect_valid
               || (!(w_take || w_skid) && !hold);
    fetch_err   = r_err;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that directly feeds the IF/ID pipeline register. It owns the PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake. It presents {Instr, Addr=PC+4} to IF/ID and drives IF/ID's hold and Flush inputs. It absorbs ID-stage branch/jump redirects and hazard-unit stalls, using a 1-entry skid buffer and in-flight response dropping.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles a request may wait for imem_ack before fetch_err is set; 0 disables.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
hold  input  1  stall from hazard unit; IF/ID must keep its contents.
redirect_valid  input  1  single-cycle pulse: taken branch/jump resolved in ID.
redirect_addr  input  32  redirect target; bits [1:0] ignored (forced 0).
imem_req  output  1  fetch request, level; held until imem_ack.
imem_addr  output  32  fetch address; stable while imem_req=1.
imem_ack  input  1  response strobe, 1 cycle; may arrive in the same cycle as imem_req rises.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
Instr  output  32  instruction to IF/ID.
Addr  output  32  fetched PC+4 to IF/ID.
if_id_hold  output  1  to IF/ID hold.
if_id_flush  output  1  to IF/ID Flush.
fetch_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, skid buffer empty, timeout counter=0, fetch_err=0, imem_req=0, Instr=0, Addr=0, if_id_hold=0, if_id_flush=1.
- The first imem_req is raised in the first cycle after rst_n deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - SKID: buffer full, no request.
  - DROP: redirect arrived while a request was outstanding; imem_req stays 1 with the old address until ack, and the returned data is discarded.
- Fetch acceptance: imem_ack in FETCH, with no redirect that cycle.
  - If hold=0: Instr=imem_rdata and Addr=pc+4 combinationally, if_id_flush=0, pc<=pc+4, stay in FETCH.
  - If hold=1: {rdata, pc+4} captured into the skid buffer, pc<=pc+4, go to SKID.
- SKID: Instr/Addr come from the buffer. When hold=0, the buffer is consumed (IF/ID latches it that edge) and the state returns to FETCH, so the next request rises the cycle after.
- No valid instruction and hold=0 (waiting on ack, or in DROP): if_id_flush=1, inserting a bubble of all zeros into IF/ID.
- if_id_hold=hold at all times, except it is forced to 0 when redirect_valid=1.
- Redirect (highest priority, overrides hold):
  - pc<=redirect_addr&~3, skid buffer cleared, if_id_flush=1 that cycle.
  - If a request is outstanding and imem_ack=0, go to DROP; otherwise go to FETCH.
  - An ack arriving in the same cycle as the redirect is discarded.
- DROP: on imem_ack the data is discarded and the state goes to FETCH; the next request (new pc) rises the following cycle.
  - A second redirect in DROP updates pc only; the state stays in DROP.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Timeout:
  - The counter increments every cycle imem_req=1 && imem_ack=0, and clears on ack.
  - When the counter reaches TIMEOUT, fetch_err<=1, which is sticky until reset.
  - The request continues; fetch_err does not alter the fetch flow.
- Reset asserted mid-request: immediate return to reset values; any late ack is not tracked.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory (ack same cycle as req) -> imem_addr sequence 0,4,8,C on consecutive cycles; Addr 4,8,C,10; if_id_flush=0 after the first fetch.
- 2-wait-state memory -> each instruction is preceded by 2 cycles with if_id_flush=1; pc advances only on ack; fetch_err stays 0.
- hold=1 for 3 cycles when the ack for addr 0x10 arrives -> data held in SKID, imem_req=0 during hold, if_id_hold=1; after release, Instr=word@0x10, Addr=0x14, then the next req addr=0x14.
- redirect_valid with redirect_addr=0x103 while a 3-cycle fetch of 0x20 is outstanding -> if_id_flush=1, DROP until ack, word@0x20 never presented, next imem_addr=0x100, Addr=0x104.
- Redirect in the same cycle as ack and hold=1 -> ack data discarded, if_id_hold=0, pc=target; redirect_addr=0xFFFFFFFC then sequential fetch -> next address 0x0.
- TIMEOUT=4, memory never acks -> fetch_err=1 after 4 cycles of unanswered req, stays 1; rst_n low mid-wait -> all outputs at reset values asynchronously.
